// File: rtl/bcd_7seg_scan_if.sv
// rtl/bcd_7seg_scan_if.sv - BCD capture inputs and multiplexed 7-segment outputs
// master drives the BCD word; slave is the display scanner.
interface bcd_7seg_scan_if;
  logic [15:0] bcd_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_sync;

  modport master (
    output bcd_in,
    output load,
    input  seg,
    input  an,
    input  frame_sync
  );

  modport slave (
    input  bcd_in,
    input  load,
    output seg,
    output an,
    output frame_sync
  );
endinterface

// File: rtl/bcd_7seg_scan.sv
// rtl/bcd_7seg_scan.sv - 4-digit BCD capture and time-multiplexed 7-segment scan
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_7seg_scan #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned DIV_W          = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_7seg_scan_if.slave  bus
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [15:0]      shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_sync_q, frame_sync_d;
  logic             tick;
  logic [3:0]       digit;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= 16'h0000;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      an_q         <= 4'b0000;
      seg_q        <= 7'h00;
      frame_sync_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    frame_sync_d = tick && (idx_q == 2'd3);
    shadow_d     = bus.load ? bus.bcd_in : shadow_q;
  end

  // Display registers are driven from the pre-edge idx/shadow, giving one cycle of latency.
  always_comb begin
    case (idx_q)
      2'd0:    digit = shadow_q[3:0];
      2'd1:    digit = shadow_q[7:4];
      2'd2:    digit = shadow_q[11:8];
      default: digit = shadow_q[15:12];
    endcase
    an_d  = 4'b0001 << idx_q;
    seg_d = decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3: if (shadow_q[15:12] == 4'd0) begin
        an_d  = 4'b0000;
        seg_d = 7'h00;
      end
      2'd2: if (shadow_q[15:8] == 8'd0) begin
        an_d  = 4'b0000;
        seg_d = 7'h00;
      end
      2'd1: if (shadow_q[15:4] == 12'd0) begin
        an_d  = 4'b0000;
        seg_d = 7'h00;
      end
      default: ;
    endcase
`endif
  end

  assign bus.an         = AN_ACTIVE_LOW  ? ~an_q  : an_q;
  assign bus.seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign bus.frame_sync = frame_sync_q;

endmodule
